// File: rtl/qam_dac_pkg.sv
// Shared types, constants and helpers for the QAM DAC SPI output stage.
package qam_dac_pkg;

  // Sequencer states:
  //   IDLE    | waiting for a sample tick
  //   SHIFT_A | frame A (I channel) on the wire
  //   GAP_A   | sync_n high between frame A and frame B
  //   SHIFT_B | frame B (Q channel, updates both outputs) on the wire
  //   GAP_B   | trailing sync_n high time before the next update may start
  typedef enum logic [2:0] {
    IDLE,
    SHIFT_A,
    GAP_A,
    SHIFT_B,
    GAP_B
  } state_e;

  localparam int FRAME_BITS     = 24;
  localparam int GAP_CYCLES     = 2;
  localparam int MIN_SAMPLE_DIV = 102;
  localparam int SHIFT_EDGES    = 2 * FRAME_BITS;

  // DAC code for one channel: optionally flip the sign bit to get offset binary.
  function automatic logic [15:0] dac_code(input logic [15:0] s, input logic offset_binary);
    dac_code = offset_binary ? {~s[15], s[14:0]} : s;
  endfunction

endpackage

// File: rtl/spi_frame_tx.sv
// One 24-bit SPI frame: sync_n low, MSB first, sclk = clk/2 idling high.
// The DAC samples din on the falling sclk edge; din changes with the rising edge.
module spi_frame_tx
  import qam_dac_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic [FRAME_BITS-1:0] word_i,
  output logic                  done_o,
  output logic                  sclk_o,
  output logic                  sync_n_o,
  output logic                  din_o
);

  localparam int CNT_W = $clog2(SHIFT_EDGES + 1);

  logic                  active_q;
  logic [CNT_W-1:0]      edge_cnt_q;
  logic [FRAME_BITS-1:0] shreg_q;
  logic                  sclk_q;
  logic                  sync_n_q;
  logic                  din_q;

  // Combinational so the sequencer leaves SHIFT on the same edge that ends the frame.
  assign done_o   = active_q && (edge_cnt_q == CNT_W'(1));
  assign sclk_o   = sclk_q;
  assign sync_n_o = sync_n_q;
  assign din_o    = din_q;

  // Frame shifter: the start edge presents bit 23, then 48 edges alternate fall/rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q   <= 1'b0;
      edge_cnt_q <= '0;
      shreg_q    <= '0;
      sclk_q     <= 1'b1;
      sync_n_q   <= 1'b1;
      din_q      <= 1'b0;
    end else if (start_i) begin
      active_q   <= 1'b1;
      edge_cnt_q <= CNT_W'(SHIFT_EDGES);
      shreg_q    <= {word_i[FRAME_BITS-2:0], 1'b0};
      sclk_q     <= 1'b1;
      sync_n_q   <= 1'b0;
      din_q      <= word_i[FRAME_BITS-1];
    end else if (active_q) begin
      edge_cnt_q <= edge_cnt_q - CNT_W'(1);
      if (sclk_q) begin
        sclk_q <= 1'b0;
      end else begin
        sclk_q <= 1'b1;
        if (edge_cnt_q == CNT_W'(1)) begin
          sync_n_q <= 1'b1;
          din_q    <= 1'b0;
          active_q <= 1'b0;
        end else begin
          din_q   <= shreg_q[FRAME_BITS-1];
          shreg_q <= {shreg_q[FRAME_BITS-2:0], 1'b0};
        end
      end
    end
  end

endmodule

// File: rtl/qam_dac_spi_out.sv
// QAM modulator output stage: decimates mod_iq to the DAC update rate and
// sends I then Q as two 24-bit SPI frames to a dual 16-bit serial DAC.
module qam_dac_spi_out
  import qam_dac_pkg::*;
#(
  parameter int          SAMPLE_DIV    = 128,
  parameter logic [7:0]  CMD_A         = 8'h00,
  parameter logic [7:0]  CMD_B         = 8'h11,
  parameter bit          OFFSET_BINARY = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [31:0] mod_iq,
  input  logic        clr_overrun,
  output logic        dac_sclk,
  output logic        dac_sync_n,
  output logic        dac_din,
  output logic        sample_tick,
  output logic        busy,
  output logic        overrun
);

  localparam int CW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;

  logic [CW-1:0]         smp_cnt_q, smp_cnt_d;
  logic                  tick;
  state_e                state_q;
  logic [1:0]            gap_cnt_q;
  logic [FRAME_BITS-1:0] frame_b_q;
  logic                  sample_tick_q;
  logic                  busy_q;
  logic                  overrun_q;
  logic                  tx_start;
  logic                  tx_done;
  logic [FRAME_BITS-1:0] tx_word;
  logic [FRAME_BITS-1:0] frame_a_w;

  assign tick      = enable && (smp_cnt_q == CW'(SAMPLE_DIV - 1));
  assign frame_a_w = {CMD_A, dac_code(mod_iq[31:16], OFFSET_BINARY)};

  // Frame A goes straight from the input on the tick; frame B was latched at the same tick.
  assign tx_start = ((state_q == IDLE) && tick) ||
                    ((state_q == GAP_A) && (gap_cnt_q == 2'd0));
  assign tx_word  = (state_q == IDLE) ? frame_a_w : frame_b_q;

  assign sample_tick = sample_tick_q;
  assign busy        = busy_q;
  assign overrun     = overrun_q;

  // Next sample count: free-runs 0..SAMPLE_DIV-1 while enabled, parked at 0 otherwise.
  always_comb begin
    smp_cnt_d = smp_cnt_q + CW'(1);
    if (!enable || tick) begin
      smp_cnt_d = '0;
    end
  end

  // Sample counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      smp_cnt_q <= '0;
    end else begin
      smp_cnt_q <= smp_cnt_d;
    end
  end

  // Update sequencer: capture, A/B framing with gaps, busy and sticky overrun.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      gap_cnt_q     <= 2'd0;
      frame_b_q     <= '0;
      sample_tick_q <= 1'b0;
      busy_q        <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      sample_tick_q <= 1'b0;
      if (tick && busy_q) begin
        overrun_q <= 1'b1;
      end else if (clr_overrun) begin
        overrun_q <= 1'b0;
      end
      case (state_q)
        IDLE: begin
          if (tick) begin
            frame_b_q     <= {CMD_B, dac_code(mod_iq[15:0], OFFSET_BINARY)};
            sample_tick_q <= 1'b1;
            busy_q        <= 1'b1;
            state_q       <= SHIFT_A;
          end
        end
        SHIFT_A: begin
          if (tx_done) begin
            gap_cnt_q <= 2'(GAP_CYCLES - 1);
            state_q   <= GAP_A;
          end
        end
        GAP_A: begin
          if (gap_cnt_q == 2'd0) begin
            state_q <= SHIFT_B;
          end else begin
            gap_cnt_q <= gap_cnt_q - 2'd1;
          end
        end
        SHIFT_B: begin
          if (tx_done) begin
            gap_cnt_q <= 2'(GAP_CYCLES - 1);
            state_q   <= GAP_B;
          end
        end
        GAP_B: begin
          if (gap_cnt_q == 2'd0) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            gap_cnt_q <= gap_cnt_q - 2'd1;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  spi_frame_tx u_tx (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (tx_start),
    .word_i   (tx_word),
    .done_o   (tx_done),
    .sclk_o   (dac_sclk),
    .sync_n_o (dac_sync_n),
    .din_o    (dac_din)
  );

endmodule
